restoring_divider: RTL and testbench

Iterative unsigned restoring divider: accepts a dividend/divisor pair on a START pulse, produces one quotient bit per clock MSB-first, and reports quotient and remainder with a one-cycle DONE pulse. Each iteration uses a borrow-look-ahead subtractor, the subtract-direction counterpart of the team's carry-look-ahead adder. It sits in the arithmetic datapath library alongside the adders and is driven by a simple start/busy/done controller.

---
 rtl/arith_pkg.sv | 29 ++
 rtl/borrow_look_ahead_subtractor.sv | 50 +++++
 rtl/restoring_divider.sv | 132 +++++++++++++
 tb/tb_restoring_divider.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath library.
//   - State encodings for the start/busy/done controllers.
//   - clog2 helper that sizes the iteration counters.
package arith_pkg;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_RUN_ENC    = 2'd1;
  localparam logic [1:0] ST_FINISH_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_RUN    = ST_RUN_ENC,
    ST_FINISH = ST_FINISH_ENC
  } state_e;

  // Ceiling log2. clog2(n) bits hold any value from 0 to n-1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/borrow_look_ahead_subtractor.sv
// Combinational borrow-look-ahead subtractor: DIFF = A - B - B_IN.
//   A, B   : WIDTH-bit minuend and subtrahend
//   B_IN   : borrow in
//   DIFF   : WIDTH-bit difference
//   B_OUT  : borrow out (1 when A < B + B_IN)
// Generate g = ~A & B (this bit borrows on its own); propagate
// p = ~(A ^ B) (an incoming borrow passes through when the bits are equal).
module borrow_look_ahead_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_IN,
  output logic [WIDTH-1:0] DIFF,
  output logic             B_OUT
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   brw;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_terms
      assign gen[gi]  = ~A[gi] & B[gi];
      assign prop[gi] = ~(A[gi] ^ B[gi]);
      assign DIFF[gi] = A[gi] ^ B[gi] ^ brw[gi];
    end
  endgenerate

  // Each borrow is expanded directly from the g/p terms and B_IN rather
  // than rippling through the previous borrow.
  always_comb begin
    logic acc;
    logic pp;
    brw[0] = B_IN;
    for (int i = 0; i < WIDTH; i++) begin
      acc = gen[i];
      pp  = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & gen[j]);
        pp  = pp & prop[j];
      end
      brw[i+1] = acc | (pp & B_IN);
    end
  end

  assign B_OUT = brw[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   CLK, RST     : clock, synchronous active-high reset
//   START        : request, accepted in IDLE or FINISH
//   DIVIDEND     : unsigned dividend, sampled on accept
//   DIVISOR      : unsigned divisor, sampled on accept
//   BUSY         : high during the WIDTH RUN cycles
//   DONE         : one-cycle pulse in FINISH
//   QUOTIENT     : last completed quotient (all ones on divide by zero)
//   REMAINDER    : last completed remainder (dividend on divide by zero)
//   DIV_BY_ZERO  : last completed operation had a zero divisor
module restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             DIV_BY_ZERO
);

  localparam int CW = clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;     // partial remainder R
  logic [WIDTH-1:0] dsr_q, dsr_d;     // latched divisor
  logic [WIDTH-1:0] work_q, work_d;   // dividend shifts out MSB, quotient in LSB
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;     // visible results, updated only on completion
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             borrow;

  assign r_shift = {rem_q[WIDTH-1:0], work_q[WIDTH-1]};

  borrow_look_ahead_subtractor #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .A    (r_shift),
    .B    ({1'b0, dsr_q}),
    .B_IN (1'b0),
    .DIFF (trial),
    .B_OUT(borrow)
  );

  always_comb begin
    logic [WIDTH-1:0] work_nxt;
    logic [WIDTH:0]   rem_nxt;
    state_d  = state_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rmd_d    = rmd_q;
    dbz_d    = dbz_q;
    work_nxt = {work_q[WIDTH-2:0], ~borrow};
    rem_nxt  = borrow ? r_shift : trial;

    case (state_q)
      ST_RUN: begin
        rem_d  = rem_nxt;
        work_d = work_nxt;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_FINISH;
          quo_d   = work_nxt;
          // Final remainder is below the divisor, so its top bit is zero.
          rmd_d   = rem_nxt[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: begin  // ST_IDLE, ST_FINISH
        state_d = ST_IDLE;
        if (START) begin
          if (DIVISOR == '0) begin
            state_d = ST_FINISH;
            quo_d   = '1;
            rmd_d   = DIVIDEND;
            dbz_d   = 1'b1;
          end else begin
            // DIV_BY_ZERO is left alone here so all three visible
            // results stay stable until this operation completes.
            state_d = ST_RUN;
            dsr_d   = DIVISOR;
            work_d  = DIVIDEND;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      dsr_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign BUSY        = (state_q == ST_RUN);
  assign DONE        = (state_q == ST_FINISH);
  assign QUOTIENT    = quo_q;
  assign REMAINDER   = rmd_q;
  assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec;
  int n_err;
  int last_q;
  int last_r;
  int last_dz;

  restoring_divider #(.WIDTH(W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .DIVIDEND   (dividend),
    .DIVISOR    (divisor),
    .BUSY       (busy),
    .DONE       (done),
    .QUOTIENT   (quotient),
    .REMAINDER  (remainder),
    .DIV_BY_ZERO(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);
    end
  endtask

  // One operation from the current (IDLE or FINISH) cycle through its DONE cycle.
  // stray=1 pulses START with other operands in the second RUN cycle.
  task automatic run_op(input int a, input int b, input bit stray);
    int  eq;
    int  er;
    bit  dz;
    dz = (b == 0);
    eq = dz ? (1 << W) - 1 : a / b;
    er = dz ? a : a % b;

    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    // Operands are free to change after the accept edge.
    dividend = W'($urandom_range(0, 15));
    divisor  = W'($urandom_range(0, 15));

    if (!dz) begin
      for (int k = 1; k <= W; k++) begin
        check("run_busy", int'(busy), 1);
        check("run_done", int'(done), 0);
        check("hold_q", int'(quotient), last_q);
        check("hold_r", int'(remainder), last_r);
        if (k == 2 && stray) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end

    check("fin_done", int'(done), 1);
    check("fin_busy", int'(busy), 0);
    check("quotient", int'(quotient), eq);
    check("remainder", int'(remainder), er);
    check("div_by_zero", int'(div_by_zero), int'(dz));
    if (!dz)
      check("invariant", int'((int'(quotient) * b + int'(remainder) == a) && (int'(remainder) < b)), 1);
    $display("op %0d / %0d -> q=%0d r=%0d dz=%0d (model q=%0d r=%0d)",
             a, b, quotient, remainder, div_by_zero, eq, er);
    last_q  = eq;
    last_r  = er;
    last_dz = int'(dz);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_q"}, int'(quotient), 0);
    check({tag, "_r"}, int'(remainder), 0);
    check({tag, "_dz"}, int'(div_by_zero), 0);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    last_q   = 0;
    last_r   = 0;
    last_dz  = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(1);

    // Directed cases
    run_op(13, 4, 1'b0);
    idle(1);
    run_op(15, 1, 1'b0);
    idle(2);
    run_op(3, 9, 1'b0);
    idle(1);
    run_op(7, 0, 1'b0);
    idle(1);

    // Stray START during RUN is ignored; START held in FINISH runs back-to-back.
    run_op(13, 4, 1'b1);
    run_op(9, 2, 1'b0);
    idle(1);

    // Reset mid-RUN aborts without a DONE pulse.
    dividend = W'(13);
    divisor  = W'(4);
    start    = 1'b1;
    tick();              // t+1
    start    = 1'b0;
    tick();              // t+2
    tick();              // t+3
    rst = 1'b1;
    tick();              // t+4
    rst = 1'b0;
    check_reset_outputs("midrun_rst");
    last_q = 0;
    last_r = 0;
    idle(3);
    run_op(10, 3, 1'b0);
    idle(1);

    // RST and START together: reset wins.
    rst      = 1'b1;
    start    = 1'b1;
    dividend = W'(11);
    divisor  = W'(2);
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check_reset_outputs("rst_start");
    last_q = 0;
    last_r = 0;
    idle(2);

    // Exhaustive sweep, back-to-back.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(a, b, 1'b0);
    idle(1);

    // Random operations with random gaps and stray STARTs.
    for (int n = 0; n < 60; n++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
